encoder_mac_sequencer: RTL and testbench
========================================

# encoder_mac_sequencer

Time-multiplexed controller and accumulator for the VAE level-1 encoder's four linear outputs: c1 (mean 1), d1 (var 1), c2 (mean 2) and d2 (var 2). It replaces 36 parallel multipliers and four 9-input adders with one conditional-add datapath sequenced over 40 cycles. Weights and biases are read from an external combinational ROM. Results feed the downstream softplus / sqrt / epsilon stage, which is started from `done`.

## Interface
Parameters:
- WIDTH, 16, data width; signed fixed point Q3.12 (1 sign, 3 integer, 12 fraction bits)
- N_IN, 9, number of binary input pixels
- ACC_W, 20, internal accumulator width (WIDTH + 4 guard bits)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-low (0 resets on the next rising edge of clk)
- start  input  1  request a new encode; sampled only in IDLE
- in  input  N_IN  binary pixels; latched on the start-accept edge
- w_addr  output  6  ROM address, equal to row*10 + k (k = 0..8 weights, k = 9 bias)
- w_data  input  WIDTH  signed ROM word for the current w_addr, valid in the same cycle
- c1, d1, c2, d2  output  WIDTH  registered results, rows 0, 1, 2, 3
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when all four results are final
- valid  output  1  high from done until the next start is accepted

## Operation
- States: IDLE, ACC, BIAS, DONE.
- IDLE:
  - On start=1: latch `in` into in_q, set row=0, k=0, acc=0, then go to ACC.
  - On start=0: stay in IDLE.
- ACC (k = 0..8):
  - w_addr = row*10 + k.
  - acc += in_q[k] ? sign_extend(w_data) : 0. Because each pixel is exactly 1.0 or 0, the product needs no multiplier.
  - After k=8, go to BIAS.
- BIAS:
  - w_addr = row*10 + 9.
  - Compute sum = acc + sign_extend(w_data), then saturate to WIDTH: above 32767 gives 0x7FFF, below -32768 gives 0x8000.
  - Write the saturated value to the result register for this row.
  - If row=3, go to DONE. Otherwise row += 1, k=0, acc=0, and return to ACC.
- DONE: done=1 for this one cycle, then unconditionally go to IDLE.
- ROM map: row 0 = mean weights 11..91 plus BIAS_MEAN_1; row 1 = var weights 11..91 plus BIAS_VAR_1; row 2 = mean weights 12..92 plus BIAS_MEAN_2; row 3 = var weights 12..92 plus BIAS_VAR_2.
- start is ignored in ACC, BIAS and DONE. There is no queueing; back-to-back runs need start held or re-asserted in IDLE.
- Only the BIAS result saturates. The accumulator never wraps: 10 terms fit in ACC_W=20.
- Reset (rst=0 at an edge), from any state:
  - state=IDLE, row=0, k=0, acc=0, in_q=0.
  - c1=d1=c2=d2=0.
  - busy=0, done=0, valid=0.
  - w_addr=0.
  - A run interrupted by reset produces no partial done.
- w_addr is 0 in IDLE and DONE.
- Mid-run behaviour: result registers not yet rewritten keep their previous run's values. valid falls on start accept, so consumers must qualify results with done or valid.

## Timing
- Cycle 0: start accepted at the rising edge (state IDLE, start=1).
- Cycles 1–40: busy=1.
  - Row r occupies cycles 10r+1 .. 10r+10.
  - ACC on the first 9 cycles of the row, BIAS on the 10th.
- Results become visible one cycle after their row's BIAS cycle:
  - c1 at cycle 11.
  - d1 at cycle 21.
  - c2 at cycle 31.
  - d2 at cycle 41.
- Cycle 41: done=1, busy=0, valid=1.
- Cycle 42: IDLE. The earliest next accept is at the cycle-42 edge.
- Start-to-done latency is 41 cycles. Throughput is one encode per 42 cycles.
- w_addr is registered with the state, so the ROM sees the address in the cycle in which its data is consumed.

## Test plan
- Basic:
  - Stimulus: ROM weights all 0x0100, biases 0x0000, in=9'h1FF, start pulsed at cycle 0.
  - Required: c1=d1=c2=d2=0x0900; done high only at cycle 41; busy high for cycles 1–40.
- Bias only:
  - Stimulus: in=9'h000, biases 0xF22D / 0xF165 / 0xF203 / 0xF5FB for rows 0–3.
  - Required: c1=0xF22D, d1=0xF165, c2=0xF203, d2=0xF5FB.
- Saturation:
  - Stimulus: row 0 weights 0x7000 and row 1 weights 0x9000, in=9'h1FF, bias 0.
  - Required: c1=0x7FFF, d1=0x8000.
  - Stimulus: row 2 weights 0x1000 with only in[0]=1.
  - Required: c2=0x1000 (no false saturation).
- Handshake:
  - Stimulus: start held high continuously.
  - Required: done at cycles 41 and 83; start pulses at cycles 5 and 41 are ignored; `in` changes after cycle 0 do not affect results.
- Reset mid-run:
  - Stimulus: rst=0 at cycle 15.
  - Required: next cycle shows busy=0, done=0, valid=0 and all results 0; no done follows; a new start then completes in 41 cycles with correct results.
- Address trace:
  - Required: w_addr sequence 0..39, one increment per cycle over cycles 1–40, and 0 otherwise.

Source files
------------

// File: rtl/encoder_mac_sequencer.sv
// Time-multiplexed MAC for the VAE level-1 encoder: four rows of nine binary-weighted
// ROM terms plus a bias, one ROM word per cycle, saturated to WIDTH on the bias cycle.
module encoder_mac_sequencer #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 9,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_IN-1:0]  in,
    output logic [5:0]       w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [1:0]       state_dbg
);

    localparam int K_W = $clog2(N_IN);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle when all four
    // results are final; valid stays high from done until the next start is accepted.
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_DONE} state_t;

    state_t             state, state_next;
    logic [1:0]         row, row_next;
    logic [K_W-1:0]     k, k_next;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [N_IN-1:0]    in_q, in_q_next;
    logic [5:0]         w_addr_next;
    logic               busy_next, done_next, valid_next;
    logic               res_wr;
    logic [WIDTH-1:0]   res_q [4];

    logic [ACC_W-1:0]   w_ext, addend, sum;
    logic [ACC_W-WIDTH:0] sum_hi;
    logic [WIDTH-1:0]   sum_sat;

    assign w_ext  = {{(ACC_W-WIDTH){w_data[WIDTH-1]}}, w_data};
    assign addend = in_q[k] ? w_ext : '0;
    assign sum    = acc + w_ext;
    assign sum_hi = sum[ACC_W-1:WIDTH-1];

    // The sum fits in WIDTH only when every bit above the WIDTH sign bit matches it.
    always_comb begin
        sum_sat = sum[WIDTH-1:0];
        if (sum_hi != '0 && sum_hi != '1) begin
            sum_sat = sum[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            row    <= '0;
            k      <= '0;
            acc    <= '0;
            in_q   <= '0;
            w_addr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state  <= state_next;
            row    <= row_next;
            k      <= k_next;
            acc    <= acc_next;
            in_q   <= in_q_next;
            w_addr <= w_addr_next;
            busy   <= busy_next;
            done   <= done_next;
            valid  <= valid_next;
            if (res_wr) res_q[row] <= sum_sat;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_ACC;
            S_ACC:  if (k == K_W'(N_IN - 1)) state_next = S_BIAS;
            S_BIAS: state_next = (row == 2'd3) ? S_DONE : S_ACC;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // w_addr walks 0..39 one step per busy cycle, which equals row*10 + k throughout.
    always_comb begin
        row_next    = row;
        k_next      = k;
        acc_next    = acc;
        in_q_next   = in_q;
        w_addr_next = w_addr;
        busy_next   = busy;
        done_next   = 1'b0;
        valid_next  = valid;
        res_wr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    in_q_next   = in;
                    row_next    = '0;
                    k_next      = '0;
                    acc_next    = '0;
                    w_addr_next = '0;
                    busy_next   = 1'b1;
                    valid_next  = 1'b0;
                end
            end
            S_ACC: begin
                acc_next    = acc + addend;
                w_addr_next = w_addr + 6'd1;
                if (k != K_W'(N_IN - 1)) k_next = k + 1'b1;
            end
            S_BIAS: begin
                res_wr = 1'b1;
                if (row == 2'd3) begin
                    w_addr_next = '0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    valid_next  = 1'b1;
                end else begin
                    row_next    = row + 2'd1;
                    k_next      = '0;
                    acc_next    = '0;
                    w_addr_next = w_addr + 6'd1;
                end
            end
            default: ;
        endcase
    end

    assign c1        = res_q[0];
    assign d1        = res_q[1];
    assign c2        = res_q[2];
    assign d2        = res_q[3];
    assign state_dbg = state;

endmodule

// File: tb/tb_encoder_mac_sequencer.sv
// Bench for encoder_mac_sequencer: ROM model, arithmetic reference of each row, and
// per-cycle traces of busy/done/valid/w_addr checked against the 42-cycle schedule.
module tb_encoder_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  in = '0;
    logic [5:0]  w_addr;
    logic [15:0] w_data;
    logic [15:0] c1, d1, c2, d2;
    logic        busy, done, valid;
    logic [1:0]  state_dbg;

    logic [15:0] rom [0:63];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        busy_t  [0:46];
    logic        done_t  [0:46];
    logic        valid_t [0:46];
    logic [5:0]  addr_t  [0:46];
    logic [15:0] res_d   [4];
    int          done_cnt;
    int          done_cyc;

    always #5 clk = ~clk;

    assign w_data = rom[w_addr];

    encoder_mac_sequencer #(.WIDTH(16), .N_IN(9), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in), .w_addr(w_addr), .w_data(w_data),
        .c1(c1), .d1(d1), .c2(c2), .d2(d2), .busy(busy), .done(done), .valid(valid),
        .state_dbg(state_dbg)
    );

    // Row result: sum of weights whose pixel is 1, plus bias, clamped to signed 16 bits.
    function automatic logic [15:0] model_row(input int r, input logic [8:0] pix);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) if (pix[k]) s += int'($signed(rom[r*10+k]));
        s += int'($signed(rom[r*10+9]));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic rom_fill(input logic [15:0] wt, input logic [15:0] bias);
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 9; k++) rom[r*10+k] = wt;
            rom[r*10+9] = bias;
        end
    endtask

    task automatic rom_random(input bit extreme);
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
        for (int i = 0; i < 40; i++) begin
            if (extreme) rom[i] = $urandom_range(1, 0) ? 16'($urandom_range(16'h7FFF, 16'h5000))
                                                       : 16'($urandom_range(16'hB000, 16'h8000));
            else rom[i] = 16'($urandom);
        end
    endtask

    // Starts one run from IDLE (called at a negedge) and records 46 cycles of outputs.
    // mode 1 adds the ignored start pulses at cycles 5 and 41; in is scrambled after accept.
    task automatic do_run(input logic [8:0] pix, input int mode);
        done_cnt = 0;
        done_cyc = -1;
        in = pix;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 46; c++) begin
            busy_t[c]  = busy;
            done_t[c]  = done;
            valid_t[c] = valid;
            addr_t[c]  = w_addr;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                res_d[0] = c1; res_d[1] = d1; res_d[2] = c2; res_d[3] = d2;
            end
            start = (mode == 1) && (c == 5 || c == 41);
            in = 9'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b1;
        in = 9'h1FF;
        rom_fill(16'h0100, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (w_addr !== 6'd0) begin n_fail++; $display("FAIL reset_w_addr got %0d want 0", w_addr); end
        n_cmp++; if ({c1, d1, c2, d2} !== 64'h0) begin n_fail++; $display("FAIL reset_results got %h want 0", {c1, d1, c2, d2}); end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        logic [5:0] ea;
        rom_fill(16'h0100, 16'h0000);
        do_run(9'h1FF, 0);
        n_cmp++; if (res_d[0] !== 16'h0900) begin n_fail++; $display("FAIL basic_c1 got %h want 0900", res_d[0]); end
        n_cmp++; if (res_d[1] !== 16'h0900) begin n_fail++; $display("FAIL basic_d1 got %h want 0900", res_d[1]); end
        n_cmp++; if (res_d[2] !== 16'h0900) begin n_fail++; $display("FAIL basic_c2 got %h want 0900", res_d[2]); end
        n_cmp++; if (res_d[3] !== 16'h0900) begin n_fail++; $display("FAIL basic_d2 got %h want 0900", res_d[3]); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        for (int c = 1; c <= 46; c++) begin
            ea = (c <= 40) ? 6'(c - 1) : 6'd0;
            n_cmp++; if (busy_t[c] !== (c <= 40)) begin n_fail++; $display("FAIL basic_busy cyc %0d got %b want %b", c, busy_t[c], c <= 40); end
            n_cmp++; if (done_t[c] !== (c == 41)) begin n_fail++; $display("FAIL basic_done cyc %0d got %b want %b", c, done_t[c], c == 41); end
            n_cmp++; if (valid_t[c] !== (c >= 41)) begin n_fail++; $display("FAIL basic_valid cyc %0d got %b want %b", c, valid_t[c], c >= 41); end
            n_cmp++; if (addr_t[c] !== ea) begin n_fail++; $display("FAIL basic_w_addr cyc %0d got %0d want %0d", c, addr_t[c], ea); end
        end
    endtask

    task automatic test_mid_results;
        // Result registers update one cycle after each row's bias cycle.
        logic [15:0] obs [0:46][4];
        rom_random(1'b0);
        in = 9'h0A5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            obs[c][0] = c1; obs[c][1] = d1; obs[c][2] = c2; obs[c][3] = d2;
            @(posedge clk);
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            n_cmp++; if (obs[10*r+11][r] !== model_row(r, 9'h0A5)) begin n_fail++; $display("FAIL row_visible row %0d got %h want %h", r, obs[10*r+11][r], model_row(r, 9'h0A5)); end
        end
    endtask

    task automatic test_bias_only;
        logic [15:0] b [4];
        b[0] = 16'hF22D; b[1] = 16'hF165; b[2] = 16'hF203; b[3] = 16'hF5FB;
        rom_random(1'b0);
        for (int r = 0; r < 4; r++) rom[r*10+9] = b[r];
        do_run(9'h000, 0);
        for (int r = 0; r < 4; r++) begin
            n_cmp++; if (res_d[r] !== b[r]) begin n_fail++; $display("FAIL bias_only row %0d got %h want %h", r, res_d[r], b[r]); end
        end
    endtask

    task automatic test_saturation;
        rom_fill(16'h0000, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            rom[k] = 16'h7000; rom[10+k] = 16'h9000; rom[20+k] = 16'h1000;
        end
        do_run(9'h1FF, 0);
        n_cmp++; if (res_d[0] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got %h want 7fff", res_d[0]); end
        n_cmp++; if (res_d[1] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got %h want 8000", res_d[1]); end
        do_run(9'h001, 0);
        n_cmp++; if (res_d[2] !== 16'h1000) begin n_fail++; $display("FAIL sat_none got %h want 1000", res_d[2]); end
        n_cmp++; if (res_d[0] !== 16'h7000) begin n_fail++; $display("FAIL sat_single got %h want 7000", res_d[0]); end
    endtask

    task automatic test_handshake;
        logic [8:0]  pix0;
        logic [8:0]  pix_drv [0:90];
        logic [15:0] r1 [4];
        logic [15:0] r2 [4];
        int          dq [$];
        int          n_done;
        logic [15:0] e;
        // Ignored pulses mid-run and during DONE.
        rom_random(1'b0);
        pix0 = 9'($urandom);
        do_run(pix0, 1);
        n_cmp++; if (done_cyc !== 41) begin n_fail++; $display("FAIL pulse_done_cyc got %0d want 41", done_cyc); end
        n_cmp++; if (busy_t[43] !== 1'b0) begin n_fail++; $display("FAIL pulse_ignored got busy %b want 0", busy_t[43]); end
        for (int r = 0; r < 4; r++) begin
            e = model_row(r, pix0);
            n_cmp++; if (res_d[r] !== e) begin n_fail++; $display("FAIL pulse_result row %0d got %h want %h", r, res_d[r], e); end
        end
        // start held high: back-to-back runs with in scrambled every cycle.
        pix0 = 9'($urandom);
        in = pix0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 90; c++) begin
            if (done) begin
                dq.push_back(c);
                if (dq.size() == 1) begin r1[0] = c1; r1[1] = d1; r1[2] = c2; r1[3] = d2; end
                if (dq.size() == 2) begin r2[0] = c1; r2[1] = d1; r2[2] = c2; r2[3] = d2; end
            end
            in = 9'($urandom);
            pix_drv[c] = in;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        n_done = dq.size();
        n_cmp++; if (n_done !== 2) begin n_fail++; $display("FAIL held_done_count got %0d want 2", n_done); end
        if (n_done >= 2) begin
            n_cmp++; if (dq[0] !== 41) begin n_fail++; $display("FAIL held_done_first got %0d want 41", dq[0]); end
            n_cmp++; if (dq[1] !== 83) begin n_fail++; $display("FAIL held_done_second got %0d want 83", dq[1]); end
            for (int r = 0; r < 4; r++) begin
                e = model_row(r, pix0);
                n_cmp++; if (r1[r] !== e) begin n_fail++; $display("FAIL held_run1 row %0d got %h want %h", r, r1[r], e); end
                e = model_row(r, pix_drv[42]);
                n_cmp++; if (r2[r] !== e) begin n_fail++; $display("FAIL held_run2 row %0d got %h want %h", r, r2[r], e); end
            end
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int          n_done;
        logic [8:0]  pix;
        logic [15:0] e;
        rom_random(1'b0);
        for (int i = 0; i < 40; i++) if (rom[i] == 16'h0) rom[i] = 16'h0123;
        in = 9'h1FF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", valid); end
        n_cmp++; if ({c1, d1, c2, d2} !== 64'h0) begin n_fail++; $display("FAIL midrst_results got %h want 0", {c1, d1, c2, d2}); end
        n_done = 0;
        for (int c = 0; c < 50; c++) begin
            if (done || busy) n_done++;
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", n_done); end
        pix = 9'($urandom);
        do_run(pix, 0);
        n_cmp++; if (done_cyc !== 41) begin n_fail++; $display("FAIL midrst_rerun_latency got %0d want 41", done_cyc); end
        for (int r = 0; r < 4; r++) begin
            e = model_row(r, pix);
            n_cmp++; if (res_d[r] !== e) begin n_fail++; $display("FAIL midrst_rerun row %0d got %h want %h", r, res_d[r], e); end
        end
    endtask

    task automatic test_address_trace;
        logic [5:0] ea;
        rom_random(1'b0);
        do_run(9'($urandom), 0);
        for (int c = 1; c <= 46; c++) begin
            ea = (c <= 40) ? 6'(c - 1) : 6'd0;
            n_cmp++; if (addr_t[c] !== ea) begin n_fail++; $display("FAIL addr_trace cyc %0d got %0d want %0d", c, addr_t[c], ea); end
        end
    endtask

    task automatic test_random;
        logic [8:0]  pix;
        logic [15:0] e;
        for (int t = 0; t < 12; t++) begin
            rom_random(t[0]);
            pix = 9'($urandom);
            do_run(pix, 0);
            n_cmp++; if (done_cyc !== 41) begin n_fail++; $display("FAIL random_done run %0d got %0d want 41", t, done_cyc); end
            for (int r = 0; r < 4; r++) begin
                e = model_row(r, pix);
                n_cmp++; if (res_d[r] !== e) begin n_fail++; $display("FAIL random_result run %0d row %0d got %h want %h", t, r, res_d[r], e); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_mid_results;
        test_bias_only;
        test_saturation;
        test_handshake;
        test_reset_mid_run;
        test_address_trace;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
